// File: rtl/cube_scan_ctrl.sv
// Layer-multiplexing scan controller for the 8x8x8 LED cube: snapshots Cells once
// per frame, shifts each layer out over 8 serial lines, latches it and lights it.
module cube_scan_ctrl #(
   parameter int CLK_DIV = 1,
   parameter int DWELL   = 1024
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Enable,
   input  logic [511:0] Cells,
   output logic [7:0]   Data,
   output logic         SClk,
   output logic         Latch,
   output logic         Blank,
   output logic [7:0]   Layer,
   output logic         FrameSync,
   output logic         Busy
);

   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DWELL} state_t;

   localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

   state_t         state_q, state_d;
   logic [2:0]     layer_idx_q, layer_idx_d;
   logic [2:0]     bit_q, bit_d;
   logic           phase_q, phase_d;
   logic [7:0]     div_q, div_d;
   logic [15:0]    dwell_q, dwell_d;
   logic [511:0]   snap_q, snap_d;
   logic [7:0]     data_q, data_d;
   logic [7:0]     lit_q, lit_d;
   logic           fsync_q, fsync_d;
   logic           start_frame, start_layer;

   // One bit per row for column b of layer l.
   function automatic logic [7:0] row_bits(input logic [511:0] s,
                                           input logic [2:0]   l,
                                           input logic [2:0]   b);
      logic [7:0] v;
      for (int r = 0; r < 8; r++) begin
         v[r] = s[{l, 3'(r), b}];
      end
      return v;
   endfunction

   always_comb begin
      state_d     = state_q;
      layer_idx_d = layer_idx_q;
      bit_d       = bit_q;
      phase_d     = phase_q;
      div_d       = div_q;
      dwell_d     = dwell_q;
      snap_d      = snap_q;
      data_d      = data_q;
      lit_d       = lit_q;
      fsync_d     = 1'b0;
      start_frame = 1'b0;
      start_layer = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (Enable) start_frame = 1'b1;
         end
         S_SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = 8'd0;
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else if (bit_q == 3'd0) begin
                  phase_d = 1'b0;
                  state_d = S_BLANK;
                  lit_d   = 8'd0;
               end else begin
                  phase_d = 1'b0;
                  bit_d   = bit_q - 3'd1;
                  data_d  = row_bits(snap_q, layer_idx_q, bit_q - 3'd1);
               end
            end
         end
         S_BLANK: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            state_d = S_DWELL;
            dwell_d = DWELL_LAST;
            lit_d   = 8'd1 << layer_idx_q;
         end
         S_DWELL: begin
            if (dwell_q != 16'd0) begin
               dwell_d = dwell_q - 16'd1;
            end else if (layer_idx_q != 3'd7) begin
               layer_idx_d = layer_idx_q + 3'd1;
               start_layer = 1'b1;
            end else if (Enable) begin
               start_frame = 1'b1;
            end else begin
               state_d = S_IDLE;
               lit_d   = 8'd0;
               data_d  = 8'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The lit layer is left untouched here: the drivers keep showing it while the next one shifts.
      if (start_frame) begin
         snap_d      = Cells;
         layer_idx_d = 3'd0;
         fsync_d     = 1'b1;
      end
      if (start_frame || start_layer) begin
         state_d = S_SHIFT;
         bit_d   = 3'd7;
         phase_d = 1'b0;
         div_d   = 8'd0;
         data_d  = row_bits(snap_d, layer_idx_d, 3'd7);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         layer_idx_q <= 3'd0;
         bit_q       <= 3'd0;
         phase_q     <= 1'b0;
         div_q       <= 8'd0;
         dwell_q     <= 16'd0;
         data_q      <= 8'd0;
         lit_q       <= 8'd0;
         fsync_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         layer_idx_q <= layer_idx_d;
         bit_q       <= bit_d;
         phase_q     <= phase_d;
         div_q       <= div_d;
         dwell_q     <= dwell_d;
         data_q      <= data_d;
         lit_q       <= lit_d;
         fsync_q     <= fsync_d;
      end
      snap_q <= snap_d;
   end

   assign Data      = data_q;
   assign SClk      = (state_q == S_SHIFT) && phase_q;
   assign Latch     = (state_q == S_LATCH);
   assign Layer     = lit_q;
   assign Blank     = (lit_q == 8'd0);
   assign FrameSync = fsync_q;
   assign Busy      = (state_q != S_IDLE);

endmodule
